// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TL-UL type package shared by the register adapter and its bench.
// Carries the bus widths, the A/D channel opcodes and the two channel structs
// (host-to-device request, device-to-host response).
// -----------------------------------------------------------------------------
package tlul_pkg;

  localparam int TL_AW  = 32;        // address width
  localparam int TL_DW  = 32;        // data width
  localparam int TL_AIW = 8;         // source id width
  localparam int TL_DIW = 1;         // sink id width
  localparam int TL_SZW = 2;         // size field width (log2 bytes)
  localparam int TL_DBW = TL_DW / 8; // byte-mask width

  // A channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  // D channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;

endpackage

// File: rtl/tlul_adapter_reg.sv
// -----------------------------------------------------------------------------
// tlul_adapter_reg
// TL-UL device-side adapter: terminates an A/D channel pair and drives a
// single-cycle register-file port. At most one response is held in a
// registered slot; a new request may be accepted in the same cycle the held
// response is consumed, giving one transaction per cycle when d_ready stays 1.
//
// Handshake: a beat transfers on a channel in every cycle where its valid and
// ready are both 1 at the rising clock edge. A raised valid is held with stable
// payload until it transfers; ready may depend combinationally on the other
// channel's ready (a_ready follows d_ready when the slot is full).
//
// Ports
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   tl_i     TL-UL request from host (A channel + d_ready)
//   tl_o     TL-UL response to host (D channel + a_ready)
//   re_o     read strobe, one cycle per accepted legal Get
//   we_o     write strobe, one cycle per accepted legal Put
//   addr_o   register byte address  (a_address[RegAw-1:0])
//   wdata_o  write data             (a_data)
//   be_o     byte enables           (a_mask)
//   rdata_i  read data, sampled combinationally in the re_o cycle
//   error_i  register-side error, valid in the re_o / we_o cycle
// -----------------------------------------------------------------------------
module tlul_adapter_reg #(
  parameter int RegAw = 8,
  parameter int RegDw = 32,
  parameter int RegBw = RegDw / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tlul_pkg::tlul_h2d_t tl_i,
  output tlul_pkg::tlul_d2h_t tl_o,
  output logic                re_o,
  output logic                we_o,
  output logic [RegAw-1:0]    addr_o,
  output logic [RegDw-1:0]    wdata_o,
  output logic [RegBw-1:0]    be_o,
  input  logic [RegDw-1:0]    rdata_i,
  input  logic                error_i
);

  import tlul_pkg::*;

  // The register data path is wired straight onto the bus data field.
  if (RegDw != TL_DW) begin : g_dw_mismatch
    $error("tlul_adapter_reg: RegDw must equal tlul_pkg::TL_DW");
  end

  // ---------------------------------------------------------------------------
  // Response slot state
  // ---------------------------------------------------------------------------
  logic              outstanding;
  logic [2:0]        d_opcode_q;
  logic [TL_SZW-1:0] d_size_q;
  logic [TL_AIW-1:0] d_source_q;
  logic [TL_DW-1:0]  d_data_q;
  logic              d_error_q;

  // ---------------------------------------------------------------------------
  // A channel decode
  // ---------------------------------------------------------------------------
  logic op_get;
  logic op_put_full;
  logic op_put;
  logic proto_err;
  logic a_ready;
  logic a_ack;
  logic d_ack;
  logic strobe;
  logic rsp_error;
  logic [TL_DW-1:0] rsp_data;

  assign op_get      = (tl_i.a_opcode == Get);
  assign op_put_full = (tl_i.a_opcode == PutFullData);
  assign op_put      = op_put_full || (tl_i.a_opcode == PutPartialData);

  // Anything the register file cannot execute as a plain aligned word access
  // is rejected before a strobe is raised; the host still gets a response.
  always_comb begin
    proto_err = 1'b0;
    if (!(op_get || op_put))                  proto_err = 1'b1;
    if (tl_i.a_address[1:0] != 2'b00)         proto_err = 1'b1;
    if (tl_i.a_size > 2'd2)                   proto_err = 1'b1;
    if (op_put_full && (tl_i.a_mask != '1))   proto_err = 1'b1;
    if (tl_i.a_mask == '0)                    proto_err = 1'b1;
  end

  // The slot can take a new request when empty, or when its current response
  // leaves this cycle. Held in reset so nothing is accepted or strobed while
  // rst_ni is low.
  assign a_ready = rst_ni && (!outstanding || tl_i.d_ready);
  assign a_ack   = tl_i.a_valid && a_ready;
  assign d_ack   = outstanding && tl_i.d_ready;

  // ---------------------------------------------------------------------------
  // Register-file strobes, combinational with the accept
  // ---------------------------------------------------------------------------
  assign re_o    = a_ack && op_get && !proto_err;
  assign we_o    = a_ack && op_put && !proto_err;
  assign strobe  = re_o || we_o;

  assign addr_o  = tl_i.a_address[RegAw-1:0];
  assign wdata_o = tl_i.a_data;
  assign be_o    = tl_i.a_mask;

  // ---------------------------------------------------------------------------
  // Response payload for the transaction being accepted
  // ---------------------------------------------------------------------------
  assign rsp_error = proto_err || (error_i && strobe);

  // Errored reads return all ones so a failed read is never mistaken for data;
  // writes and unsupported opcodes carry no data.
  always_comb begin
    rsp_data = '0;
    if (op_get) begin
      rsp_data = rsp_error ? '1 : rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response slot: load on accept (also when the old response leaves in the
  // same cycle), clear on consume without a new accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_error_q   <= 1'b0;
    end else if (a_ack) begin
      outstanding <= 1'b1;
      d_opcode_q  <= op_get ? AccessAckData : AccessAck;
      d_size_q    <= tl_i.a_size;
      d_source_q  <= tl_i.a_source;
      d_data_q    <= rsp_data;
      d_error_q   <= rsp_error;
    end else if (d_ack) begin
      outstanding <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // D channel drive; param and sink are always zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = outstanding;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end

  // A channel fields this adapter does not interpret.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw]};

endmodule

// File: doc/tlul_adapter_reg.md
Name: tlul_adapter_reg

Overview:
- TL-UL device-side adapter. Terminates a TL-UL A/D channel pair and drives a simple single-cycle register-file interface.
- Sits directly downstream of a TL-UL FIFO or crossbar port. It consumes that stage's tl_d_o request stream and returns responses into its tl_d_i.
- Holds at most one outstanding transaction in a registered response slot.
- Checks protocol and access legality before any register strobe is issued.

Parameters:
- RegAw, 8: register address width; addr_o = a_address[RegAw-1:0].
- RegDw, 32: register data width; must equal tlul_pkg::TL_DW (elaboration assertion).
- RegBw, RegDw/8: byte-enable width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- tl_i  input  tlul_pkg::tlul_h2d_t  TL-UL request from host side
- tl_o  output  tlul_pkg::tlul_d2h_t  TL-UL response to host side
- re_o  output  1  register read strobe, one cycle per accepted legal Get
- we_o  output  1  register write strobe, one cycle per accepted legal Put
- addr_o  output  RegAw  register byte address
- wdata_o  output  RegDw  write data (= a_data)
- be_o  output  RegBw  byte enables (= a_mask)
- rdata_i  input  RegDw  register read data, combinational in the re_o cycle
- error_i  input  1  register-side error, valid in the re_o/we_o cycle

Behaviour:
- Reset state:
  - outstanding=0, so d_valid=0.
  - All response registers are 0: d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error.
  - re_o=we_o=0.
- Ready and accept:
  - a_ready = ~outstanding | d_ready.
  - a_ack = a_valid & a_ready.
  - d_ack = d_valid & d_ready.
- Protocol error (proto_err), evaluated on the A channel:
  - opcode not in {Get, PutFullData, PutPartialData}; or
  - a_address[1:0] != 0; or
  - a_size > 2; or
  - PutFullData with a_mask != all ones; or
  - a_mask == 0.
- Strobes, combinational with the accept:
  - re_o = a_ack & (opcode==Get) & ~proto_err.
  - we_o = a_ack & (opcode is Put) & ~proto_err.
  - addr_o, wdata_o and be_o are driven straight from the A channel at all times.
  - No strobe is issued when proto_err is set.
- Response capture, on a_ack at the clock edge:
  - outstanding <= 1.
  - d_opcode <= AccessAckData for Get, AccessAck otherwise (including illegal opcodes).
  - d_size <= a_size; d_source <= a_source; d_sink <= 0; d_param <= 0.
  - d_error <= proto_err | (error_i & (re_o|we_o)).
  - d_data <= rdata_i for a legal Get without error; all ones for an errored Get; 0 for any Put.
- Latency: A accept at cycle N → d_valid at N+1.
- Response hold: d_valid holds, and the response fields are stable, until d_ack. On d_ack without a_ack, outstanding <= 0.
- Simultaneous d_ack and a_ack: outstanding stays 1 and the response registers load the new transaction. This gives back-to-back throughput of 1 transaction/cycle when the host keeps d_ready=1.
- Response stall: d_ready=0 with outstanding=1 forces a_ready=0. No strobes are issued and A is held off.
- a_valid deasserting without acceptance: no effect.
- Reset asserted mid-transaction: the pending response is dropped, d_valid goes 0 immediately (async), and no strobe is issued while rst_ni=0.
- tl_o fields not listed above (a_ready aside) are driven to 0.

Test Plan:
- Read: Get addr 0x10, size 2, source 0x5, mask 0xF, rdata_i=0xDEADBEEF, d_ready=1 → re_o pulse at N, addr_o=0x10; at N+1 d_valid=1, AccessAckData, d_data=0xDEADBEEF, d_source=0x5, d_error=0.
- Partial write: PutPartialData addr 0x24, mask 0x3, data 0x1234ABCD → we_o pulse, be_o=0x3, wdata_o=0x1234ABCD; response AccessAck, d_data=0, d_error=0.
- Protocol errors: Get addr 0x13 → no re_o, AccessAckData, d_error=1, d_data=0xFFFFFFFF. PutFullData mask 0x7 → no we_o, AccessAck, d_error=1. Opcode 3'h7 → no strobe, d_error=1.
- Backpressure: hold d_ready=0 for 5 cycles after a Get while a second Put waits → a_ready=0, no we_o, d fields stable. Raise d_ready → same-cycle Put accept, we_o pulse, next response AccessAck.
- Streaming: 8 back-to-back Gets with d_ready=1 → one re_o per cycle, 8 consecutive d_valid cycles with matching sources 0..7. error_i=1 on the 4th → only the 4th has d_error=1 and d_data=all ones.
- Reset mid-flight: assert rst_ni=0 while d_valid=1 → d_valid=0 asynchronously. After release: a_ready=1, no spurious re_o/we_o.
